// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: datapath request side and single-port memory side of
// the memory access unit, bundled for one port on the unit.
// Optional feature macro: ACV_EN adds priv (1 = user mode) and acv.
//
// Handshake: while mem_en=1 the unit holds mem_we/mem_addr/mem_wdata stable.
// An access completes on the rising edge where mem_en=1 and mem_ready=1; the
// memory may stall by holding mem_ready=0. mem_ready with mem_en=0 means
// nothing. mem_rdata only has to be valid in the completing cycle of a read.
interface mem_access_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] ea;
  logic [15:0] store_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] load_data;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
`ifdef ACV_EN
  logic        priv;
  logic        acv;

  // The unit itself.
  modport slave (
    input  start, op, ea, store_data, mem_rdata, mem_ready, priv,
    output busy, done, err, load_data, mem_en, mem_we, mem_addr, mem_wdata, acv
  );

  // The environment: datapath plus memory.
  modport master (
    output start, op, ea, store_data, mem_rdata, mem_ready, priv,
    input  busy, done, err, load_data, mem_en, mem_we, mem_addr, mem_wdata, acv
  );
`else
  // The unit itself.
  modport slave (
    input  start, op, ea, store_data, mem_rdata, mem_ready,
    output busy, done, err, load_data, mem_en, mem_we, mem_addr, mem_wdata
  );

  // The environment: datapath plus memory.
  modport master (
    output start, op, ea, store_data, mem_rdata, mem_ready,
    input  busy, done, err, load_data, mem_en, mem_we, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: performs the data-memory transaction for LD/LDR/LDI/ST/
// STR/STI from a captured effective address. Indirect ops read a pointer
// first, then access the pointed-to word. MAR drives mem_addr and MDR drives
// mem_wdata and load_data directly, so all memory outputs are registered.
// Optional feature macro: ACV_EN (user-mode access control violation check).
module mem_access_unit #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus,
  output logic [1:0]       dbgState
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PTR  = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] waitLim = 8'(WAIT_LIMIT);

  logic [1:0]  state;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        isStore;
  logic [7:0]  waitCnt;
  logic [7:0]  waitNext;
  logic        memEn;
  logic        memWe;
  logic        doneReg;
  logic        errReg;
  logic        timeout;
  logic        startViol;
  logic        ptrViol;

`ifdef ACV_EN
  logic privReg;
  logic acvReg;

  // User mode may only touch x3000..xFDFF.
  function automatic logic isViolation(input logic user, input logic [15:0] addr);
    return user && ((addr < 16'h3000) || (addr >= 16'hFE00));
  endfunction

  assign startViol = isViolation(bus.priv, bus.ea);
  assign ptrViol   = isViolation(privReg, bus.mem_rdata);
  assign bus.acv   = acvReg;
`else
  assign startViol = 1'b0;
  assign ptrViol   = 1'b0;
`endif

  // An access aborts on the stalled cycle that brings the count up to the limit.
  assign waitNext = waitCnt + 8'd1;
  assign timeout  = (waitLim != 8'd0) && !bus.mem_ready && (waitNext == waitLim);

  // Main sequencer: IDLE -> [PTR ->] ACC -> DONE -> IDLE, aborts go to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mar     <= 16'h0000;
      mdr     <= 16'h0000;
      isStore <= 1'b0;
      waitCnt <= 8'd0;
      memEn   <= 1'b0;
      memWe   <= 1'b0;
      doneReg <= 1'b0;
      errReg  <= 1'b0;
`ifdef ACV_EN
      privReg <= 1'b0;
      acvReg  <= 1'b0;
`endif
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mar     <= bus.ea;
            mdr     <= bus.store_data;
            isStore <= bus.op[0];
            waitCnt <= 8'd0;
            errReg  <= 1'b0;
`ifdef ACV_EN
            privReg <= bus.priv;
            acvReg  <= startViol;
`endif
            if (startViol) begin
              state   <= DONE;
              doneReg <= 1'b1;
            end else begin
              state <= bus.op[1] ? PTR : ACC;
              memEn <= 1'b1;
              memWe <= !bus.op[1] && bus.op[0];
            end
          end
        end
        PTR: begin
          if (bus.mem_ready) begin
            waitCnt <= 8'd0;
            if (ptrViol) begin
              memEn   <= 1'b0;
              state   <= DONE;
              doneReg <= 1'b1;
`ifdef ACV_EN
              acvReg  <= 1'b1;
`endif
            end else begin
              // Back-to-back: mem_en stays high, address and we switch now.
              mar   <= bus.mem_rdata;
              memWe <= isStore;
              state <= ACC;
            end
          end else if (timeout) begin
            memEn   <= 1'b0;
            state   <= DONE;
            doneReg <= 1'b1;
            errReg  <= 1'b1;
          end else begin
            waitCnt <= waitNext;
          end
        end
        ACC: begin
          if (bus.mem_ready) begin
            memEn   <= 1'b0;
            memWe   <= 1'b0;
            state   <= DONE;
            doneReg <= 1'b1;
            if (!isStore) begin
              mdr <= bus.mem_rdata;
            end
          end else if (timeout) begin
            memEn   <= 1'b0;
            memWe   <= 1'b0;
            state   <= DONE;
            doneReg <= 1'b1;
            errReg  <= 1'b1;
          end else begin
            waitCnt <= waitNext;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = doneReg;
  assign bus.err       = errReg;
  assign bus.load_data = mdr;
  assign bus.mem_en    = memEn;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = mar;
  assign bus.mem_wdata = mdr;
  assign dbgState      = state;

endmodule
